// File: rtl/seg7_scan.sv
// 8-digit multiplexed hex display driver with a per-frame snapshot of the displayed word.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_LZ_EN.
module seg7_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      snap;
  logic [31:0]      frame;
  logic [3:0]       nib;
  logic             tick;
  logic             blank;

  assign tick  = (cnt == CNT_W'(SCAN_DIV - 1));
  // Digit 0 reads the live word because that is the slot where the snapshot is taken.
  assign frame = (idx == 3'd0) ? value : snap;
  assign nib   = frame[{idx, 2'b00} +: 4];

`ifdef SEG7_BLANK_LZ_EN
  logic [2:0] msd;

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (frame[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] hex(input logic [3:0] h);
    case (h)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      default: hex = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= 3'd0;
      snap <= 32'h0;
      an   <= 8'hFF;
      seg  <= 7'h7F;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        if (idx == 3'd0) snap <= value;
        idx <= idx + 3'd1;
        if (blank) begin
          an  <= 8'hFF;
          seg <= 7'h7F;
        end else begin
          an  <= ~(8'b1 << idx);
          seg <= hex(nib);
        end
      end
    end
  end

endmodule
